// File: rtl/rnn_cell_engine_if.sv
// Memory-mapped bus between the HPS slave port and the RNN step engine.
interface rnn_cell_engine_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  modport master (
    output read, write, addr, data_in,
    input  data_out, busy, done
  );

  modport slave (
    input  read, write, addr, data_in,
    output data_out, busy, done
  );
endinterface

// File: rtl/rnn_cell_engine.sv
// Elman RNN step engine: h' = hardtanh(Wih*x + Whh*h + b), y = d.h' + db, on one shared MAC.
// The CPU loads operands over the bus, writes start, then polls done.
module rnn_cell_engine #(
  parameter int unsigned HID    = 4,
  parameter int unsigned IN_LEN = 4,
  parameter int unsigned DW     = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned ACC_W  = 40
) (
  input logic              clk,
  input logic              rst_n,
  rnn_cell_engine_if.slave bus
);

  localparam int unsigned NumWih = HID * IN_LEN;
  localparam int unsigned NumWhh = HID * HID;
  localparam int unsigned AwWih  = (NumWih > 1) ? $clog2(NumWih) : 1;
  localparam int unsigned AwWhh  = $clog2(NumWhh);
  localparam int unsigned AwH    = $clog2(HID);
  localparam int unsigned AwX    = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int unsigned RowLen = IN_LEN + HID;

  typedef logic signed [DW-1:0]    word_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t One  = acc_t'(1) << FRAC;
  localparam acc_t YMax = (acc_t'(1) << (DW - 1)) - acc_t'(1);
  localparam acc_t YMin = -YMax - acc_t'(1);

  typedef enum logic [2:0] {StIdle, StMac, StAct, StDense, StOut} state_e;

  state_e state_q, state_d;

  // Stores are sized to a power of two so every index is exactly wide enough.
  word_t wih     [2**AwWih];
  word_t whh     [2**AwWhh];
  word_t bias    [2**AwH];
  word_t dw      [2**AwH];
  word_t xv      [2**AwX];
  word_t h_cur_q [2**AwH];
  word_t h_nxt_q [2**AwH];
  word_t db_q, y_q;

  acc_t              acc_q, acc_sum, acc_shr;
  logic [7:0]        cnt_q;
  logic [AwH-1:0]    row_q, row_inc;
  logic              done_q, busy;
  logic [31:0]       data_out_q, rd_data;
  word_t             op_a, op_b, h_val, y_val;
  logic signed [2*DW-1:0] prod;

  logic [3:0]  region;
  logic [31:0] idx, hk, wi, wh;
  logic        wr_ok, ctrl_wr, start, clear, mac_last, dense_last, row_last;
  logic        unused_bits;

  assign region      = bus.addr[15:12];
  assign idx         = {20'd0, bus.addr[11:0]};
  assign wr_ok       = bus.write && !busy;
  assign ctrl_wr     = wr_ok && (region == 4'd0) && (idx == 32'd0);
  assign start       = ctrl_wr && bus.data_in[0];
  assign clear       = ctrl_wr && bus.data_in[1];
  assign unused_bits = ^{bus.addr[31:16], bus.data_in};

  assign mac_last   = 32'(cnt_q) == RowLen - 1;
  assign dense_last = 32'(cnt_q) == HID - 1;
  assign row_last   = 32'(row_q) == HID - 1;
  assign row_inc    = row_q + 1'b1;

  assign hk = 32'(cnt_q) - IN_LEN;
  assign wi = 32'(row_q) * IN_LEN + 32'(cnt_q);
  assign wh = 32'(row_q) * HID + hk;

  // Operand stores: no reset, the CPU always loads before starting.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (region)
        4'd1: if (idx < NumWih) wih[idx[AwWih-1:0]] <= bus.data_in[DW-1:0];
        4'd2: if (idx < NumWhh) whh[idx[AwWhh-1:0]] <= bus.data_in[DW-1:0];
        4'd3: if (idx < HID) bias[idx[AwH-1:0]] <= bus.data_in[DW-1:0];
        4'd4: if (idx < HID) dw[idx[AwH-1:0]] <= bus.data_in[DW-1:0];
        4'd5: if (idx == 32'd0) db_q <= bus.data_in[DW-1:0];
        4'd6: if (idx < IN_LEN) xv[idx[AwX-1:0]] <= bus.data_in[DW-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StMac;
      StMac:   if (mac_last) state_d = StAct;
      StAct:   state_d = row_last ? StDense : StMac;
      StDense: if (dense_last) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    op_a = '0;
    op_b = '0;
    if (state_q == StMac) begin
      if (32'(cnt_q) < IN_LEN) begin
        op_a = wih[wi[AwWih-1:0]];
        op_b = xv[cnt_q[AwX-1:0]];
      end else begin
        op_a = whh[wh[AwWhh-1:0]];
        op_b = h_cur_q[hk[AwH-1:0]];
      end
    end else if (state_q == StDense) begin
      op_a = dw[cnt_q[AwH-1:0]];
      op_b = h_nxt_q[cnt_q[AwH-1:0]];
    end
  end

  assign prod    = op_a * op_b;
  assign acc_sum = acc_q + acc_t'(prod);
  assign acc_shr = acc_q >>> FRAC;

  always_comb begin
    if (acc_shr > One)       h_val = word_t'(One);
    else if (acc_shr < -One) h_val = word_t'(-One);
    else                     h_val = word_t'(acc_shr);
    if (acc_shr > YMax)      y_val = word_t'(YMax);
    else if (acc_shr < YMin) y_val = word_t'(YMin);
    else                     y_val = word_t'(acc_shr);
  end

  always_comb begin
    rd_data = '0;
    case (region)
      4'd0: begin
        if (idx == 32'd0)      rd_data = {30'd0, done_q, busy};
        else if (idx == 32'd1) rd_data = 32'(y_q);
      end
      4'd1: if (idx < NumWih) rd_data = 32'(wih[idx[AwWih-1:0]]);
      4'd2: if (idx < NumWhh) rd_data = 32'(whh[idx[AwWhh-1:0]]);
      4'd3: if (idx < HID) rd_data = 32'(bias[idx[AwH-1:0]]);
      4'd4: if (idx < HID) rd_data = 32'(dw[idx[AwH-1:0]]);
      4'd5: if (idx == 32'd0) rd_data = 32'(db_q);
      4'd6: if (idx < IN_LEN) rd_data = 32'(xv[idx[AwX-1:0]]);
      4'd7: if (idx < HID) rd_data = 32'(h_cur_q[idx[AwH-1:0]]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      for (int i = 0; i < 2**AwH; i++) begin
        h_cur_q[i] <= '0;
        h_nxt_q[i] <= '0;
      end
    end else begin
      if (bus.read) data_out_q <= rd_data;
      unique case (state_q)
        StIdle: begin
          if (wr_ok && region == 4'd7 && idx < HID) h_cur_q[idx[AwH-1:0]] <= bus.data_in[DW-1:0];
          if (clear) begin
            for (int i = 0; i < 2**AwH; i++) h_cur_q[i] <= '0;
          end
          if (start) begin
            done_q <= 1'b0;
            acc_q  <= acc_t'(bias[AwH'(0)]) <<< FRAC;
            cnt_q  <= '0;
            row_q  <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_sum;
          cnt_q <= mac_last ? 8'd0 : cnt_q + 8'd1;
        end
        StAct: begin
          h_nxt_q[row_q] <= h_val;
          if (row_last) begin
            acc_q <= acc_t'(db_q) <<< FRAC;
          end else begin
            row_q <= row_inc;
            acc_q <= acc_t'(bias[row_inc]) <<< FRAC;
          end
        end
        StDense: begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 8'd1;
        end
        StOut: begin
          // New hidden state only becomes visible here, so every row used the old h.
          y_q    <= y_val;
          done_q <= 1'b1;
          for (int i = 0; i < 2**AwH; i++) h_cur_q[i] <= h_nxt_q[i];
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;

endmodule
